// File: rtl/mcp_adc_scan_if.sv
// SPI link between the scanner (master) and an MCP3208-class ADC (slave).
interface mcp_adc_scan_if;
    logic SCLK;
    logic nCS;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output nCS, output MOSI, input MISO);
    modport slave  (input SCLK, input nCS, input MOSI, output MISO);
endinterface

// File: rtl/mcp_adc_scan.sv
// Round-robin MCP3208 scanner: per-channel SPI frames, peak hold with reset/ack
// handshake, and atomic publication of each completed scan on ain.
module mcp_adc_scan #(
    parameter int unsigned        NUM_CH    = 6,
    parameter int unsigned        CLK_DIV   = 2,
    parameter int unsigned        GAP       = 2,
    parameter logic [NUM_CH-1:0]  PEAK_MASK = 6'b000011
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    mcp_adc_scan_if.master        spi,
    output logic [12*NUM_CH-1:0]  ain,
    output logic                  scan_done,
    input  logic                  pk_detect_reset,
    output logic                  pk_detect_ack
);

    localparam int unsigned    CntMax  = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int unsigned    CntW    = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);
    localparam logic [2:0]     LastCh  = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StHi, StGap} state_e;

    state_e                state;
    logic [CntW-1:0]       cnt;
    logic [4:0]            bit_n;
    logic [2:0]            ch;
    logic [11:0]           cap;
    logic [11:0]           val_q [NUM_CH];
    logic [11:0]           val_d [NUM_CH];
    logic [11:0]           smp_q [NUM_CH];
    logic [11:0]           smp_d [NUM_CH];
    logic [12*NUM_CH-1:0]  ain_d;
    logic                  frame_end;
    logic                  scan_end;

    // Command word, MSB first: start, single-ended, 3-bit channel, 14 don't-care zeros.
    function automatic logic cmd_bit(input logic [2:0] c, input logic [4:0] n);
        logic [18:0] w;
        w = {2'b11, c, 14'b0};
        return w[n];
    endfunction

    // The low half of every SCLK period lives in StSetup, so a frame is 19 x (Setup + Hi).
    // Channel values are folded in on the last GAP clock, when the capture is complete.
    always_comb begin
        frame_end = (state == StGap) && (cnt == GapLast);
        scan_end  = frame_end && (ch == LastCh);
        val_d     = val_q;
        smp_d     = smp_q;
        if (frame_end) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (ch == 3'(k)) begin
                    smp_d[k] = cap;
                    if (PEAK_MASK[k]) val_d[k] = (cap > val_q[k]) ? cap : val_q[k];
                    else              val_d[k] = cap;
                end
            end
        end
        if (scan_end && pk_detect_reset) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (PEAK_MASK[k]) val_d[k] = smp_d[k];
            end
        end
        for (int k = 0; k < int'(NUM_CH); k++) ain_d[12*k +: 12] = val_d[k];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            cnt           <= '0;
            bit_n         <= '0;
            ch            <= '0;
            cap           <= '0;
            spi.SCLK      <= 1'b0;
            spi.nCS       <= 1'b1;
            spi.MOSI      <= 1'b0;
            ain           <= '0;
            scan_done     <= 1'b0;
            pk_detect_ack <= 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                val_q[k] <= '0;
                smp_q[k] <= '0;
            end
        end else begin
            scan_done <= 1'b0;
            val_q     <= val_d;
            smp_q     <= smp_d;
            unique case (state)
                StIdle: begin
                    if (enable) begin
                        state    <= StSetup;
                        cnt      <= '0;
                        bit_n    <= 5'd18;
                        spi.nCS  <= 1'b0;
                        spi.MOSI <= cmd_bit(ch, 5'd18);
                    end
                end
                StSetup: begin
                    if (cnt == DivLast) begin
                        state    <= StHi;
                        cnt      <= '0;
                        spi.SCLK <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHi: begin
                    if (cnt == '0 && bit_n < 5'd12) cap[bit_n[3:0]] <= spi.MISO;
                    if (cnt == DivLast) begin
                        cnt      <= '0;
                        spi.SCLK <= 1'b0;
                        if (bit_n == 5'd0) begin
                            state    <= StGap;
                            spi.nCS  <= 1'b1;
                            spi.MOSI <= 1'b0;
                        end else begin
                            state    <= StSetup;
                            bit_n    <= bit_n - 5'd1;
                            spi.MOSI <= cmd_bit(ch, bit_n - 5'd1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt == GapLast) begin
                        cnt <= '0;
                        if (scan_end) begin
                            state         <= StIdle;
                            ch            <= '0;
                            ain           <= ain_d;
                            scan_done     <= 1'b1;
                            pk_detect_ack <= pk_detect_reset;
                        end else begin
                            state    <= StSetup;
                            ch       <= ch + 3'd1;
                            bit_n    <= 5'd18;
                            spi.nCS  <= 1'b0;
                            spi.MOSI <= cmd_bit(ch + 3'd1, 5'd18);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_adc_scan.sv
// Bench for mcp_adc_scan: default instance (a) and NUM_CH=8/CLK_DIV=1/no-peak instance (b),
// each driven by an ADC model that answers the channel it decodes from MOSI.
module tb_mcp_adc_scan;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [1:0]  en;
    logic [1:0]  rand_mode;
    logic [1:0]  pk_dir;
    logic [1:0]  pk_rnd;
    logic [1:0]  pk_in;
    logic [1:0]  miso_r;
    logic [1:0]  sd_w;
    logic [1:0]  ack_w;
    logic [71:0] ain_a;
    logic [95:0] ain_b;

    assign pk_in[0] = rand_mode[0] ? pk_rnd[0] : pk_dir[0];
    assign pk_in[1] = rand_mode[1] ? pk_rnd[1] : pk_dir[1];

    mcp_adc_scan_if spi_a ();
    mcp_adc_scan_if spi_b ();
    assign spi_a.MISO = miso_r[0];
    assign spi_b.MISO = miso_r[1];

    mcp_adc_scan dut_a (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (en[0]),
        .spi             (spi_a),
        .ain             (ain_a),
        .scan_done       (sd_w[0]),
        .pk_detect_reset (pk_in[0]),
        .pk_detect_ack   (ack_w[0])
    );

    mcp_adc_scan #(
        .NUM_CH    (8),
        .CLK_DIV   (1),
        .GAP       (2),
        .PEAK_MASK (8'h00)
    ) dut_b (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (en[1]),
        .spi             (spi_b),
        .ain             (ain_b),
        .scan_done       (sd_w[1]),
        .pk_detect_reset (pk_in[1]),
        .pk_detect_ack   (ack_w[1])
    );

    int          nch   [2] = '{6, 8};
    int          cdv   [2] = '{2, 1};
    int          gapv  [2] = '{2, 2};
    logic [7:0]  maskv [2] = '{8'h03, 8'h00};

    int          n_chk = 0;
    int          n_err = 0;
    logic [11:0] tbl_dir [2][8];
    logic [11:0] tbl_rnd [2][8];
    logic [11:0] cur     [2][8];
    logic [11:0] pk      [2][8];
    int          scans   [2] = '{0, 0};
    int          frames  [2] = '{0, 0};
    int          exp_ch  [2];
    int          low     [2];
    int          hi      [2];
    int          kk      [2];
    logic [18:0] cmd     [2];
    logic [2:0]  chm     [2];
    logic [11:0] dat     [2];
    logic        in_frm  [2];
    logic        ncs_p   [2];
    logic        sclk_p  [2];
    logic        sd_p    [2];

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] slice(input int i, input int k);
        return (i == 0) ? ain_a[12*k +: 12] : ain_b[12*k +: 12];
    endfunction

    // One negedge step of the ADC model and frame/scan scoreboard for instance i.
    task automatic mon_step(input int i);
        logic        ncs;
        logic        sclk;
        logic        mosi;
        logic        pkr;
        int          n;
        logic [18:0] ecmd;
        ncs  = (i == 0) ? spi_a.nCS  : spi_b.nCS;
        sclk = (i == 0) ? spi_a.SCLK : spi_b.SCLK;
        mosi = (i == 0) ? spi_a.MOSI : spi_b.MOSI;
        if (!reset_n) begin
            in_frm[i] = 1'b0;
            exp_ch[i] = 0;
            hi[i]     = 0;
            miso_r[i] = 1'b0;
            ncs_p[i]  = 1'b1;
            sclk_p[i] = 1'b0;
            sd_p[i]   = 1'b0;
            for (int k = 0; k < 8; k++) pk[i][k] = '0;
            return;
        end
        if (!ncs && ncs_p[i]) begin
            if (exp_ch[i] != 0) check_val($sformatf("d%0d_ncs_high", i), hi[i], gapv[i]);
            in_frm[i] = 1'b1;
            low[i]    = 0;
            kk[i]     = 0;
            cmd[i]    = '0;
            dat[i]    = '0;
            miso_r[i] = 1'b0;
            frames[i]++;
        end
        if (!ncs) begin
            low[i]++;
            if (sclk && !sclk_p[i]) begin
                cmd[i] = {cmd[i][17:0], mosi};
                kk[i]++;
                if (kk[i] == 5) begin
                    chm[i] = cmd[i][2:0];
                    dat[i] = rand_mode[i] ? tbl_rnd[i][chm[i]] : tbl_dir[i][chm[i]];
                end
            end
            if (!sclk && sclk_p[i]) begin
                n = 18 - kk[i];
                miso_r[i] = (n >= 0 && n <= 11) ? dat[i][n] : 1'b0;
            end
        end else if (!ncs_p[i] && in_frm[i]) begin
            check_val($sformatf("d%0d_ncs_low", i), low[i], 38 * cdv[i]);
            check_val($sformatf("d%0d_sclk_rises", i), kk[i], 19);
            ecmd = {2'b11, 3'(exp_ch[i]), 14'b0};
            check_val($sformatf("d%0d_mosi_cmd", i), cmd[i], ecmd);
            cur[i][chm[i]] = dat[i];
            exp_ch[i] = (exp_ch[i] + 1) % nch[i];
            hi[i]     = 0;
            in_frm[i] = 1'b0;
        end
        if (ncs) hi[i]++;
        if (sd_w[i]) begin
            pkr = pk_in[i];
            check_val($sformatf("d%0d_sd_pulse", i), sd_p[i], 0);
            check_val($sformatf("d%0d_scan_end_ch", i), exp_ch[i], 0);
            for (int k = 0; k < nch[i]; k++) begin
                if (!maskv[i][k] || pkr || cur[i][k] > pk[i][k]) pk[i][k] = cur[i][k];
                check_val($sformatf("d%0d_ain%0d", i, k), slice(i, k), pk[i][k]);
            end
            check_val($sformatf("d%0d_ack", i), ack_w[i], pkr);
            scans[i]++;
            if (rand_mode[i]) begin
                for (int k = 0; k < 8; k++) tbl_rnd[i][k] = 12'($urandom_range(0, 4095));
                pk_rnd[i] = ($urandom_range(0, 3) == 0);
            end
        end
        ncs_p[i]  = ncs;
        sclk_p[i] = sclk;
        sd_p[i]   = sd_w[i];
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) tbl_rnd[i][k] = 12'($urandom_range(0, 4095));
        pk_rnd = 2'b00;
        miso_r = 2'b00;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    task automatic wait_scan(input int i);
        int s;
        int t;
        s = scans[i];
        t = 0;
        while (scans[i] == s && t < 4000) begin
            @(negedge clock);
            t++;
        end
        check_val($sformatf("d%0d_scan_timeout", i), (scans[i] != s), 1);
    endtask

    initial begin
        int v0 [3];
        int e0 [3];
        int e2 [3];
        int t;
        int s0;
        int f0;
        v0 = '{12'h400, 12'h7FF, 12'h200};
        e0 = '{12'h400, 12'h7FF, 12'h7FF};
        e2 = '{12'h400, 12'h7FF, 12'h200};
        reset_n   = 1'b0;
        en        = 2'b00;
        rand_mode = 2'b10;
        pk_dir    = 2'b00;
        for (int k = 0; k < 8; k++) begin
            tbl_dir[0][k] = 12'(12'h100 * k + 12'h023);
            tbl_dir[1][k] = '0;
        end
        repeat (3) @(negedge clock);
        check_val("rst_ncs", spi_a.nCS, 1);
        check_val("rst_sclk", spi_a.SCLK, 0);
        check_val("rst_mosi", spi_a.MOSI, 0);
        check_val("rst_ain", (ain_a == '0), 1);
        check_val("rst_ack", ack_w[0], 0);
        check_val("rst_sd", sd_w[0], 0);
        reset_n = 1'b1;
        en      = 2'b11;

        wait_scan(0);
        for (int k = 0; k < 6; k++)
            check_val($sformatf("first_ain%0d", k), ain_a[12*k +: 12], 12'h100 * k + 12'h023);

        for (int j = 0; j < 3; j++) begin
            tbl_dir[0][0] = 12'(v0[j]);
            tbl_dir[0][2] = 12'(v0[j]);
            wait_scan(0);
            check_val($sformatf("peak_ch0_%0d", j), ain_a[11:0], e0[j]);
            check_val($sformatf("track_ch2_%0d", j), ain_a[35:24], e2[j]);
        end

        pk_dir[0] = 1'b1;
        tbl_dir[0][0] = 12'h150;
        wait_scan(0);
        check_val("hs_ain0", ain_a[11:0], 12'h150);
        check_val("hs_ack_rise", ack_w[0], 1);
        pk_dir[0] = 1'b0;
        tbl_dir[0][0] = 12'h100;
        wait_scan(0);
        check_val("hs_ack_fall", ack_w[0], 0);
        check_val("hs_ain0_hold", ain_a[11:0], 12'h150);
        tbl_dir[0][0] = 12'h180;
        wait_scan(0);
        check_val("hs_ain0_new", ain_a[11:0], 12'h180);
        pk_dir[0] = 1'b1;
        wait_scan(0);
        check_val("pre_rst_ack", ack_w[0], 1);

        // Asynchronous reset while SCLK is high inside a frame.
        t = 0;
        while (!(in_frm[0] && spi_a.SCLK) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check_val("rst_wait_timeout", (t < 2000), 1);
        reset_n = 1'b0;
        #1;
        check_val("midrst_sclk", spi_a.SCLK, 0);
        check_val("midrst_ncs", spi_a.nCS, 1);
        check_val("midrst_ain", (ain_a == '0), 1);
        check_val("midrst_ack", ack_w[0], 0);
        pk_dir[0] = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_scan(0);

        // Drop enable during channel 2's frame: the scan must still complete once.
        t = 0;
        while (!(in_frm[0] && exp_ch[0] == 2) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check_val("dis_wait_timeout", (t < 2000), 1);
        en[0] = 1'b0;
        s0 = scans[0];
        f0 = frames[0];
        repeat (1500) @(negedge clock);
        check_val("dis_scans", scans[0] - s0, 1);
        check_val("dis_frames", frames[0] - f0, 3);
        check_val("dis_ncs", spi_a.nCS, 1);
        en[0] = 1'b1;
        wait_scan(0);

        rand_mode[0] = 1'b1;
        repeat (8) wait_scan(0);
        check_val("b_scans_seen", (scans[1] > 10), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
